// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns one byte/half/word load or store request
// into one or two word-aligned memory transactions (two when the access
// straddles a word boundary) and returns the extended load result.
//
// state | meaning
// IDLE  | waiting for start, memory interface quiet
// ACC1  | first (or only) word transaction on the bus
// ACC2  | second word of a boundary-straddling access
// DONE  | one-cycle completion pulse, rdata updated for loads
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            LoadType,
    input  logic [1:0]            StoreType,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           rdata
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t                state_q;
    logic                  is_store_q;
    logic [2:0]            load_type_q;
    logic [1:0]            off_q;
    logic                  split_q;
    logic [3:0]            be2_q;
    logic [31:0]           wdata_q;
    logic [31:0]           lo_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [3:0]            mem_be_q;
    logic [31:0]           mem_wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic [31:0]           rdata_q;

    logic [2:0]  size_d;
    logic [7:0]  lane_mask_d;
    logic [5:0]  sh_hi_d;
    logic [31:0] first_word_d;
    logic [31:0] load_raw_d;
    logic [31:0] load_ext_d;

    // Undefined type codes fall back to a full word.
    function automatic logic [2:0] access_size(input logic st, input logic [2:0] lt,
                                               input logic [1:0] stt);
        logic [2:0] n;
        n = 3'd4;
        if (st) begin
            case (stt)
                2'b01:   n = 3'd1;
                2'b10:   n = 3'd2;
                default: n = 3'd4;
            endcase
        end else begin
            case (lt)
                3'b010, 3'b001: n = 3'd1;
                3'b101, 3'b100: n = 3'd2;
                default:        n = 3'd4;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] lt, input logic [31:0] raw);
        logic [31:0] r;
        case (lt)
            3'b010:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {24'd0, raw[7:0]};
            3'b101:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Lane mask spans 8 lanes: low nibble is the first word, high nibble the second.
    always_comb begin
        size_d       = access_size(is_store, LoadType, StoreType);
        lane_mask_d  = ((8'd1 << size_d) - 8'd1) << addr[1:0];
        sh_hi_d      = 6'd32 - {1'b0, off_q, 3'b000};
        first_word_d = mem_rdata >> {off_q, 3'b000};
        load_raw_d   = (state_q == ACC2) ? (lo_q | (mem_rdata << sh_hi_d)) : first_word_d;
        load_ext_d   = extend(load_type_q, load_raw_d);
    end

    // Sequencer with all interface outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            load_type_q <= 3'd0;
            off_q       <= 2'd0;
            split_q     <= 1'b0;
            be2_q       <= 4'd0;
            wdata_q     <= 32'd0;
            lo_q        <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        is_store_q  <= is_store;
                        load_type_q <= LoadType;
                        off_q       <= addr[1:0];
                        split_q     <= |lane_mask_d[7:4];
                        be2_q       <= lane_mask_d[7:4];
                        wdata_q     <= wdata;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store;
                        mem_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_q    <= lane_mask_d[3:0];
                        mem_wdata_q <= wdata << {addr[1:0], 3'b000};
                        busy_q      <= 1'b1;
                        state_q     <= ACC1;
                    end
                end
                ACC1: begin
                    if (mem_ready) begin
                        if (split_q) begin
                            lo_q        <= first_word_d;
                            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                            mem_be_q    <= be2_q;
                            mem_wdata_q <= wdata_q >> sh_hi_d;
                            state_q     <= ACC2;
                        end else begin
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            mem_be_q  <= 4'd0;
                            done_q    <= 1'b1;
                            if (!is_store_q) rdata_q <= load_ext_d;
                            state_q   <= DONE;
                        end
                    end
                end
                ACC2: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'd0;
                        done_q    <= 1'b1;
                        if (!is_store_q) rdata_q <= load_ext_d;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    mem_be_q  <= 4'd0;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-level memory/store model feeds a
// transaction queue and a result queue; a negedge monitor acts as the
// memory (with programmable wait cycles) and checks everything it sees.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, is_store;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] addr, wdata, mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, busy, done;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [3:0]  mem_be;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store),
        .LoadType(load_type), .StoreType(store_type), .addr(addr), .wdata(wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        int          lat;
        int          t0;
    } res_t;

    txn_t exp_txn[$];
    res_t exp_res[$];

    int          n_tests = 0;
    int          n_fail = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h8011_2233;
            32'h0000_00FC: return 32'h12AA_BBCC;
            32'h0000_0100: return 32'h5566_7734;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] b);
        logic [31:0] w;
        w = mem_word({b[31:2], 2'b00});
        return w[b[1:0]*8 +: 8];
    endfunction

    // Expected bus transactions and result, derived byte by byte.
    task automatic push_exp(input logic st, input logic [2:0] lt, input logic [1:0] stt,
                            input logic [31:0] a, input logic [31:0] wd);
        int          n;
        logic [31:0] b, w1, raw, res;
        logic [3:0]  be1, be2;
        logic [31:0] d1, d2;
        txn_t        t;
        res_t        r;
        if (st) n = (stt == 2'b01) ? 1 : (stt == 2'b10) ? 2 : 4;
        else    n = (lt == 3'b010 || lt == 3'b001) ? 1 : (lt == 3'b101 || lt == 3'b100) ? 2 : 4;
        w1 = {a[31:2], 2'b00};
        be1 = 4'd0; be2 = 4'd0; d1 = 32'd0; d2 = 32'd0; raw = 32'd0;
        for (int k = 0; k < n; k++) begin
            b = a + 32'(k);
            raw[k*8 +: 8] = byte_at(b);
            if ({b[31:2], 2'b00} == w1) begin
                be1[b[1:0]] = 1'b1;
                d1[b[1:0]*8 +: 8] = wd[k*8 +: 8];
            end else begin
                be2[b[1:0]] = 1'b1;
                d2[b[1:0]*8 +: 8] = wd[k*8 +: 8];
            end
        end
        t.addr = w1; t.we = st; t.be = be1; t.data = d1;
        exp_txn.push_back(t);
        if (be2 != 4'd0) begin
            t.addr = w1 + 32'd4; t.we = st; t.be = be2; t.data = d2;
            exp_txn.push_back(t);
        end
        case (lt)
            3'b010:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {24'd0, raw[7:0]};
            3'b101:  res = {{16{raw[15]}}, raw[15:0]};
            3'b100:  res = {16'd0, raw[15:0]};
            default: res = raw;
        endcase
        r.is_load = !st;
        r.rdata   = res;
        r.lat     = (be2 != 4'd0) ? (4 + 2 * wait_n) : (3 + wait_n);
        r.t0      = cyc;
        exp_res.push_back(r);
    endtask

    // Memory responder and monitor.
    initial begin
        txn_t t;
        res_t r;
        logic [31:0] m;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_req) begin
                    chk_eq("busy_in_acc", 32'(busy), 32'd1);
                    if (exp_txn.size() == 0) begin
                        chk_eq("unexpected_txn", 32'd1, 32'd0);
                        mem_ready = 1'b1;
                    end else begin
                        t = exp_txn[0];
                        chk_eq("txn_addr", mem_addr, t.addr);
                        chk_eq("txn_we", 32'(mem_we), 32'(t.we));
                        chk_eq("txn_be", 32'(mem_be), 32'(t.be));
                        if (t.we) begin
                            m = {{8{t.be[3]}}, {8{t.be[2]}}, {8{t.be[1]}}, {8{t.be[0]}}};
                            chk_eq("txn_wdata", mem_wdata & m, t.data);
                        end
                        if (wcnt >= wait_n) begin
                            mem_ready = 1'b1;
                            mem_rdata = mem_word(mem_addr);
                            void'(exp_txn.pop_front());
                            wcnt = 0;
                        end else begin
                            mem_ready = 1'b0;
                            mem_rdata = $urandom;
                            wcnt++;
                        end
                    end
                end else begin
                    chk_eq("idle_we_be", {27'd0, mem_we, mem_be}, 32'd0);
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                    wcnt = 0;
                end
                if (done) begin
                    if (exp_res.size() == 0) begin
                        chk_eq("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        r = exp_res.pop_front();
                        chk_eq("txn_left", 32'(exp_txn.size()), 32'd0);
                        chk_eq("latency", 32'(cyc - r.t0 + 1), 32'(r.lat));
                        chk_eq("busy_in_done", 32'(busy), 32'd1);
                        if (r.is_load) begin
                            chk_eq("load_rdata", rdata, r.rdata);
                            last_rdata = r.rdata;
                        end else begin
                            chk_eq("store_keeps_rdata", rdata, last_rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
        if (done !== 1'b1) chk_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input logic st, input logic [2:0] lt, input logic [1:0] stt,
                          input logic [31:0] a, input logic [31:0] wd, input int waits);
        @(negedge clk);
        wait_n = waits;
        is_store = st; load_type = lt; store_type = stt; addr = a; wdata = wd;
        start = 1'b1;
        push_exp(st, lt, stt, a, wd);
        @(negedge clk);
        start = 1'b0;
        addr = $urandom; wdata = $urandom; is_store = 1'($urandom);
        load_type = 3'($urandom); store_type = 2'($urandom);
        wait_done();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_req"}, 32'(mem_req), 32'd0);
        chk_eq({tag, "_we"}, 32'(mem_we), 32'd0);
        chk_eq({tag, "_addr"}, mem_addr, 32'd0);
        chk_eq({tag, "_be"}, 32'(mem_be), 32'd0);
        chk_eq({tag, "_wdata"}, mem_wdata, 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
        chk_eq({tag, "_done"}, 32'(done), 32'd0);
        chk_eq({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] lt_tab [8] = '{3'b000, 3'b010, 3'b101, 3'b001, 3'b100, 3'b011, 3'b110, 3'b111};

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; load_type = 3'd0;
        store_type = 2'd0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        access(1'b1, 3'b000, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        access(1'b0, 3'b010, 2'b00, 32'h0000_0203, 32'h0, 0);
        access(1'b1, 3'b000, 2'b10, 32'h0000_0007, 32'h0000_ABCD, 0);
        access(1'b0, 3'b100, 2'b00, 32'h0000_00FF, 32'h0, 2);
        access(1'b0, 3'b001, 2'b00, 32'h0000_0201, 32'h0, 1);
        access(1'b0, 3'b101, 2'b00, 32'h0000_0102, 32'h0, 0);
        access(1'b0, 3'b000, 2'b00, 32'h0000_00FE, 32'h0, 1);
        access(1'b0, 3'b011, 2'b00, 32'h0000_00FD, 32'h0, 0);
        access(1'b1, 3'b000, 2'b01, 32'h0000_0103, 32'h1234_5677, 0);
        access(1'b1, 3'b000, 2'b11, 32'h0000_0006, 32'hCAFE_F00D, 1);
        access(1'b0, 3'b000, 2'b00, 32'hFFFF_FFFE, 32'h0, 0);
        access(1'b1, 3'b000, 2'b00, 32'hFFFF_FFFD, 32'h8765_4321, 0);

        // Reset while the second word of a split store is pending.
        @(negedge clk);
        wait_n = 3;
        is_store = 1'b1; load_type = 3'b000; store_type = 2'b10;
        addr = 32'h0000_0007; wdata = 32'h0000_1234; start = 1'b1;
        push_exp(1'b1, 3'b000, 2'b10, 32'h0000_0007, 32'h0000_1234);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !(mem_req === 1'b1 && mem_addr === 32'h8); i++) @(negedge clk);
        chk_eq("reached_acc2", mem_addr, 32'h0000_0008);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        exp_txn.delete();
        exp_res.delete();
        last_rdata = 32'd0;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        access(1'b0, 3'b010, 2'b00, 32'h0000_0203, 32'h0, 0);

        // Start held high: the second access starts only after DONE and
        // address changes while busy do not disturb the first.
        @(negedge clk);
        wait_n = 1;
        is_store = 1'b0; load_type = 3'b000; store_type = 2'b00;
        addr = 32'h0000_01FE; wdata = 32'h0; start = 1'b1;
        push_exp(1'b0, 3'b000, 2'b00, 32'h0000_01FE, 32'h0);
        @(negedge clk);
        addr = 32'h0000_0FF0;
        wait_done();
        @(negedge clk);
        is_store = 1'b1; store_type = 2'b01; addr = 32'h0000_0302; wdata = 32'h0000_005A;
        push_exp(1'b1, 3'b000, 2'b01, 32'h0000_0302, 32'h0000_005A);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        for (int i = 0; i < 24; i++) begin
            access(1'($urandom_range(0, 1)), lt_tab[$urandom_range(0, 7)],
                   2'($urandom_range(0, 3)), $urandom & 32'h0000_0FFF, $urandom,
                   $urandom_range(0, 2));
        end

        repeat (4) @(negedge clk);
        chk_eq("res_queue_empty", 32'(exp_res.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
